// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue queue: opcodes, default width
// and the bit positions inside the packed result flags.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_MIN  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_SIGN  = 3;

    // Opcodes 8-15 have no ALU meaning; the top bit alone identifies them.
    function automatic logic op_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry is read
// straight out of the storage array so consumers see a registered value.
module sync_fifo #(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH_DATA-1:0] wdata,
    output logic [WIDTH_DATA-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH_DATA-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU commands, presents the oldest one to an external ALU and
// registers its result for a valid/ready consumer.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_shamt,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_illegal
);

    localparam int CMD_W = 4 + 2 * WIDTH + 5;

    logic [CMD_W-1:0] push_data;
    logic [CMD_W-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [3:0]       head_op;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [4:0]       head_sh;

    logic             cap_illegal;
    logic [WIDTH-1:0] cap_result;
    logic [3:0]       cap_flags;

    assign push_data = {in_opcode, in_a, in_b, in_shamt};
    assign {head_op, head_a, head_b, head_sh} = head;

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && (!out_valid || out_ready);

    sync_fifo #(
        .WIDTH_DATA (CMD_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Stale storage contents must not reach the ALU once the queue drains.
    always_comb begin
        alu_opcode     = '0;
        alu_input1     = '0;
        alu_input2     = '0;
        alu_shiftValue = '0;
        if (!empty) begin
            alu_opcode     = head_op;
            alu_input1     = head_a;
            alu_input2     = head_b;
            alu_shiftValue = head_sh;
        end
    end

    always_comb begin
        cap_illegal = op_illegal(head_op);
        cap_result  = '0;
        cap_flags   = '0;
        if (cap_illegal) begin
            cap_flags[FLAG_ZERO] = 1'b1;
        end else begin
            cap_result            = alu_result;
            cap_flags[FLAG_CARRY] = alu_carry;
            cap_flags[FLAG_ZERO]  = alu_zero;
            cap_flags[FLAG_OVF]   = alu_overflow;
            cap_flags[FLAG_SIGN]  = alu_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            out_illegal <= 1'b0;
        end else if (pop) begin
            out_valid   <= 1'b1;
            out_result  <= cap_result;
            out_flags   <= cap_flags;
            out_illegal <= cap_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural 16-bit ALU;
// a negedge monitor checks delivered results against a scoreboard.
module tb_alu_issue_queue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [4:0]  in_shamt;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_input1;
    logic [15:0] alu_input2;
    logic [4:0]  alu_shiftValue;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_sign;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic        out_illegal;

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  f;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   checks   = 0;
    int   passes   = 0;
    int   cyc      = 0;
    int   accepted = 0;
    exp_t held;
    bit   hold_v   = 1'b0;

    alu_issue_queue #(.WIDTH(16), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_shamt       (in_shamt),
        .alu_opcode     (alu_opcode),
        .alu_input1     (alu_input1),
        .alu_input2     (alu_input2),
        .alu_shiftValue (alu_shiftValue),
        .alu_result     (alu_result),
        .alu_carry      (alu_carry),
        .alu_zero       (alu_zero),
        .alu_overflow   (alu_overflow),
        .alu_sign       (alu_sign),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_flags      (out_flags),
        .out_illegal    (out_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural ALU; illegal opcodes give garbage the queue must ignore.
    logic [16:0] sum17;
    always_comb begin
        sum17        = '0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_zero     = 1'b0;
        alu_sign     = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                sum17        = {1'b0, alu_input1} + {1'b0, alu_input2};
                alu_result   = sum17[15:0];
                alu_carry    = sum17[16];
                alu_overflow = (alu_input1[15] == alu_input2[15])
                             && (alu_result[15] != alu_input1[15]);
            end
            OP_SUB: begin
                alu_result   = alu_input1 - alu_input2;
                alu_carry    = alu_input1 < alu_input2;
                alu_overflow = (alu_input1[15] != alu_input2[15])
                             && (alu_result[15] != alu_input1[15]);
            end
            OP_AND:  alu_result = alu_input1 & alu_input2;
            OP_OR:   alu_result = alu_input1 | alu_input2;
            OP_SLL:  alu_result = alu_input1 << alu_shiftValue;
            OP_MIN:  alu_result = ($signed(alu_input1) < $signed(alu_input2))
                                ? alu_input1 : alu_input2;
            OP_SLT:  alu_result = {15'b0, $signed(alu_input1) < $signed(alu_input2)};
            OP_SLTU: alu_result = {15'b0, alu_input1 < alu_input2};
            default: alu_result = 16'hDEAD;
        endcase
        if (alu_opcode[3]) begin
            alu_carry    = 1'b1;
            alu_overflow = 1'b1;
            alu_zero     = 1'b1;
            alu_sign     = 1'b1;
        end else begin
            alu_zero = (alu_result == 16'h0000);
            alu_sign = alu_result[15];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("hold_stable", {out_valid, out_result, out_flags, out_illegal},
                    {1'b1, held});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result: got %h expected none", out_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 32'(out_result), 32'(e.r));
                    chk("flags", 32'(out_flags), 32'(e.f));
                    chk("illegal", 32'(out_illegal), 32'(e.ill));
                    pop_cyc.push_back(cyc);
                end
            end
            hold_v = out_valid && !out_ready;
            held   = {out_result, out_flags, out_illegal};
        end
    end

    task automatic send(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] sh,
                        input logic [15:0] er, input logic [3:0] ef,
                        input logic ei, input bit keep);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_shamt  = sh;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                if (keep) sb.push_back({er, ef, ei});
                accepted++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int n0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        idle(2);
        rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_outputs", {out_result, out_flags, out_illegal}, 0);
        chk("rst_alu_zero", {alu_opcode, alu_input1, alu_shiftValue}, 0);

        // ADD overflow and two-edge latency
        out_ready = 1'b1;
        send(OP_ADD, 16'h7FFF, 16'h0001, 5'd0, 16'h8000, 4'b1100, 1'b0, 1'b1);
        chk("lat_k", 32'(out_valid), 0);
        idle(1);
        chk("lat_k1", 32'(out_valid), 1);
        idle(3);

        // backpressure: five fit, the sixth is refused
        out_ready = 1'b0;
        accepted  = 0;
        send(OP_ADD,  16'h0001, 16'h0002, 5'd0, 16'h0003, 4'b0000, 1'b0, 1'b1);
        send(OP_ADD,  16'hFFFF, 16'h0001, 5'd0, 16'h0000, 4'b0011, 1'b0, 1'b1);
        send(OP_OR,   16'h00F0, 16'h0F00, 5'd0, 16'h0FF0, 4'b0000, 1'b0, 1'b1);
        send(OP_SLTU, 16'h0001, 16'hFFFF, 5'd0, 16'h0001, 4'b0000, 1'b0, 1'b1);
        send(OP_SLT,  16'h0001, 16'hFFFF, 5'd0, 16'h0000, 4'b0010, 1'b0, 1'b1);
        chk("accepted5", 32'(accepted), 5);
        in_valid  = 1'b1;
        in_opcode = OP_ADD;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("drain_sb", 32'(sb.size()), 0);
        chk("drain_valid", 32'(out_valid), 0);

        // streaming at full rate
        n0 = pop_cyc.size();
        send(OP_SUB, 16'h0005, 16'h0005, 5'd0, 16'h0000, 4'b0010, 1'b0, 1'b1);
        send(OP_AND, 16'hF0F0, 16'h3C3C, 5'd0, 16'h3030, 4'b0000, 1'b0, 1'b1);
        send(OP_SLL, 16'h0001, 16'h0000, 5'd4, 16'h0010, 4'b0000, 1'b0, 1'b1);
        idle(3);
        chk("stream_sb", 32'(sb.size()), 0);
        if (pop_cyc.size() >= n0 + 3) begin
            chk("b2b_gap1", 32'(pop_cyc[n0+1] - pop_cyc[n0]), 1);
            chk("b2b_gap2", 32'(pop_cyc[n0+2] - pop_cyc[n0+1]), 1);
        end else begin
            checks++;
            $display("FAIL stream_count: got %0d expected %0d",
                     pop_cyc.size() - n0, 3);
        end

        // illegal opcode then a normal one
        send(4'd12,  16'h1234, 16'h5678, 5'd3, 16'h0000, 4'b0010, 1'b1, 1'b1);
        send(OP_ADD, 16'h0002, 16'h0003, 5'd0, 16'h0005, 4'b0000, 1'b0, 1'b1);
        idle(4);
        chk("illegal_sb", 32'(sb.size()), 0);

        // reset with queued work: nothing old may come out
        out_ready = 1'b0;
        send(OP_ADD, 16'h1111, 16'h1111, 5'd0, 16'h0, 4'b0, 1'b0, 1'b0);
        send(OP_ADD, 16'h2222, 16'h2222, 5'd0, 16'h0, 4'b0, 1'b0, 1'b0);
        send(OP_OR,  16'h3333, 16'h0000, 5'd0, 16'h0, 4'b0, 1'b0, 1'b0);
        send(OP_AND, 16'h4444, 16'hFFFF, 5'd0, 16'h0, 4'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_out", {out_result, out_flags, out_illegal}, 0);
        chk("mid_rst_alu", {alu_opcode, alu_input1, alu_input2}, 0);
        out_ready = 1'b1;
        idle(6);
        chk("no_stale", 32'(out_valid), 0);

        // same-edge push and pop at DEPTH-1, across pointer wrap
        out_ready = 1'b0;
        send(OP_ADD,  16'h0010, 16'h0020, 5'd0, 16'h0030, 4'b0000, 1'b0, 1'b1);
        send(OP_ADD,  16'h0100, 16'h0200, 5'd0, 16'h0300, 4'b0000, 1'b0, 1'b1);
        send(OP_MIN,  16'h8000, 16'h0001, 5'd0, 16'h8000, 4'b1000, 1'b0, 1'b1);
        send(OP_SLTU, 16'h0005, 16'h0003, 5'd0, 16'h0000, 4'b0010, 1'b0, 1'b1);
        chk("occ_before", 32'(dut.u_fifo.count), 3);
        out_ready = 1'b1;
        send(OP_SUB,  16'h0003, 16'h0005, 5'd0, 16'hFFFE, 4'b1001, 1'b0, 1'b1);
        chk("occ_after", 32'(dut.u_fifo.count), 3);
        idle(6);
        chk("wrap_sb", 32'(sb.size()), 0);
        chk("wrap_valid", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter WIDTH, default 16, datapath width of operands and result.
REQ-002 Parameter DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream command valid.
REQ-006 in_ready  output  1  command accepted on an edge where in_valid && in_ready.
REQ-007 in_opcode / in_a / in_b / in_shamt  input  4 / WIDTH / WIDTH / 5  command fields.
REQ-008 alu_opcode / alu_input1 / alu_input2 / alu_shiftValue  output  4 / WIDTH / WIDTH / 5  drive ALU opcode, input1, input2, shiftValue.
REQ-009 alu_result  input  WIDTH  combinational ALU result for the driven command.
REQ-010 alu_carry / alu_zero / alu_overflow / alu_sign  input  1 each  ALU flags.
REQ-011 out_valid  output  1  registered result valid.
REQ-012 out_ready  input  1  downstream accepts on an edge where out_valid && out_ready.
REQ-013 out_result  output  WIDTH  registered result.
REQ-014 out_flags  output  4  {sign, overflow, zero, carry}.
REQ-015 out_illegal  output  1  opcode of the delivered result was 8-15.

Function
REQ-016 Accepted commands SHALL be stored in a DEPTH-entry FIFO in arrival order; in_ready SHALL equal !full and SHALL NOT depend on same-cycle pop.
REQ-017 alu_* outputs SHALL be driven from the FIFO head registers only, with no combinational path from in_* ports; they SHALL be all-zero when the FIFO is empty.
REQ-018 The head SHALL be popped and alu_result/flags captured into the output register on an edge where the FIFO is non-empty and (!out_valid || out_ready).
REQ-019 Latency: a command accepted at edge k into an empty FIFO with an empty output register SHALL give out_valid=1 after edge k+1; there is no bypass path.
REQ-020 With out_valid && out_ready and an empty FIFO, out_valid SHALL clear after that edge; with a non-empty FIFO the next result SHALL load in the same edge, so throughput is one result per cycle.
REQ-021 out_result, out_flags and out_illegal SHALL hold stable while out_valid && !out_ready.
REQ-022 An opcode in the range 8-15 SHALL be popped normally and SHALL deliver out_result=0, out_flags=4'b0010 and out_illegal=1; ALU inputs SHALL be ignored for it.
REQ-023 Push and pop on the same edge SHALL both take effect and leave the occupancy unchanged.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; the occupancy count SHALL be clog2(DEPTH)+1 bits wide.
REQ-025 Total buffering SHALL be DEPTH+1 commands (FIFO plus output register).

Reset
REQ-026 When rst=1 at an edge, the FIFO SHALL be emptied, out_valid, out_result, out_flags and out_illegal SHALL be 0, and in_ready SHALL be 1 after that edge.
REQ-027 Reset mid-operation SHALL discard all queued and pending results, and no stale result SHALL appear after reset.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode constants (ADD=0 SUB=1 AND=2 OR=3 SLL=4 MIN=5 SLT=6 SLTU=7), the default WIDTH, and the out_flags bit indices.
REQ-029 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH_DATA and DEPTH); the output register and control SHALL live in alu_issue_queue.

Verification (the bench connects a behavioural 16-bit ALU model)
REQ-030 Push ADD 0x7FFF, 0x0001 with out_ready=1 -> out_valid two edges after acceptance, out_result=0x8000, overflow=1, sign=1.
REQ-031 Hold out_ready=0 and offer 6 commands back to back -> 5 accepted, in_ready=0 on the 6th; releasing out_ready gives results in order, one per cycle.
REQ-032 Stream SUB 5-5, AND, SLL 0x0001<<4 with out_ready=1 continuously -> results 0x0000 (zero=1), then correct AND, then 0x0010, back to back.
REQ-033 Opcode 4'd12 with any operands -> out_result=0, out_flags=4'b0010, out_illegal=1; the following command is unaffected.
REQ-034 Assert rst with 3 queued commands and out_valid=1 -> after the edge out_valid=0 and in_ready=1, and no old result ever appears.
REQ-035 Push on the same edge as a pop at occupancy DEPTH-1 -> occupancy unchanged and order preserved across pointer wrap.
